// File: rtl/mtm_alu_pkg.sv
// Shared types for the ALU frame controller: FSM state encoding and error-flag layout.
package mtm_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    LOAD = 2'd2,
    TX   = 2'd3
  } state_t;

  localparam int ERR_W    = 4;
  localparam int ERR_DATA = 3;
  localparam int ERR_CRC  = 2;
  localparam int ERR_OP   = 1;
  localparam int ERR_TMO  = 0;

endpackage

// File: rtl/mtm_alu_ctrl_timer.sv
// CALC watchdog: counts enabled cycles since the last clear and flags expiry
// on the TIMEOUT_CYC-th enabled cycle.
module mtm_alu_ctrl_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] count_reg;

  assign expire = enable && (count_reg == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expire) begin
      count_reg <= count_reg + W'(1);
    end
  end

endmodule

// File: rtl/mtm_alu_ctrl.sv
// Frame sequencer between deserializer, ALU core and serializer.
// Optional CALC watchdog enabled by defining MTM_ALU_CTRL_TIMEOUT_EN.
module mtm_alu_ctrl
  import mtm_alu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             des_valid,
  input  logic [2:0]       des_err,
  output logic             des_ready,
  output logic             core_start,
  input  logic             core_done,
  output logic             ser_load,
  output logic             ser_err_frame,
  output logic [ERR_W-1:0] ser_err_flags,
  input  logic             ser_busy,
  output logic             busy,
  output logic             drop,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  state_t state_reg;
  logic   tx_first_reg;
  logic   tmo_expire;
  logic   calc_entry;

  assign calc_entry = (state_reg == IDLE) && des_valid && !(|des_err);
  // Only combinational output: lets the load fire the very cycle ser_busy drops.
  assign ser_load   = (state_reg == LOAD) && !ser_busy;

`ifdef MTM_ALU_CTRL_TIMEOUT_EN
  mtm_alu_ctrl_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (calc_entry),
    .enable (state_reg == CALC),
    .expire (tmo_expire)
  );
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = |TIMEOUT_CYC;
  assign tmo_expire         = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      tx_first_reg  <= 1'b0;
      des_ready     <= 1'b1;
      core_start    <= 1'b0;
      ser_err_frame <= 1'b0;
      ser_err_flags <= '0;
      busy          <= 1'b0;
      drop          <= 1'b0;
      frame_cnt     <= '0;
      err_cnt       <= '0;
    end else begin
      core_start <= 1'b0;
      if (des_valid && state_reg != IDLE) drop <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (des_valid) begin
            des_ready <= 1'b0;
            busy      <= 1'b1;
            if (|des_err) begin
              ser_err_frame          <= 1'b1;
              ser_err_flags          <= '0;
              ser_err_flags[ERR_DATA] <= des_err[2];
              ser_err_flags[ERR_CRC]  <= des_err[1];
              ser_err_flags[ERR_OP]   <= des_err[0];
              state_reg              <= LOAD;
            end else begin
              core_start <= 1'b1;
              state_reg  <= CALC;
            end
          end
        end
        CALC: begin
          // A result arriving on the expiry cycle still counts as a good frame.
          if (core_done) begin
            ser_err_frame <= 1'b0;
            ser_err_flags <= '0;
            state_reg     <= LOAD;
          end else if (tmo_expire) begin
            ser_err_frame          <= 1'b1;
            ser_err_flags          <= '0;
            ser_err_flags[ERR_TMO] <= 1'b1;
            state_reg              <= LOAD;
          end
        end
        LOAD: begin
          if (!ser_busy) begin
            tx_first_reg <= 1'b1;
            state_reg    <= TX;
          end
        end
        TX: begin
          tx_first_reg <= 1'b0;
          // ser_busy only rises the cycle after the load, so skip the first TX cycle.
          if (!tx_first_reg && !ser_busy) begin
            state_reg     <= IDLE;
            des_ready     <= 1'b1;
            busy          <= 1'b0;
            ser_err_frame <= 1'b0;
            ser_err_flags <= '0;
            frame_cnt     <= frame_cnt + CNT_W'(1);
            if (ser_err_frame && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mtm_alu_ctrl.sv
// Randomized self-checking bench for mtm_alu_ctrl against a frame-level reference model.
module tb_mtm_alu_ctrl;

  localparam int CNT_W = 4;
  localparam int TMO   = 16;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             des_valid;
  logic [2:0]       des_err;
  logic             des_ready;
  logic             core_start;
  logic             core_done;
  logic             ser_load;
  logic             ser_err_frame;
  logic [3:0]       ser_err_flags;
  logic             ser_busy;
  logic             busy;
  logic             drop;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;

  int checks = 0;
  int failures = 0;
  int n_frames = 0;
  int n_errs = 0;
  bit drop_exp = 1'b0;

  mtm_alu_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .des_valid(des_valid), .des_err(des_err),
    .des_ready(des_ready), .core_start(core_start), .core_done(core_done),
    .ser_load(ser_load), .ser_err_frame(ser_err_frame), .ser_err_flags(ser_err_flags),
    .ser_busy(ser_busy), .busy(busy), .drop(drop), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One frame: des_valid at cycle 0; core_done at done_dly (0 = never);
  // ser_busy held for `hold` cycles on LOAD entry, then high tx_len cycles after the load.
  task automatic run_frame(input logic [2:0] err, input int done_dly, input int hold,
                           input int tx_len, input bit inject, input bit stray);
    bit         exp_ef;
    logic [3:0] exp_flags;
    int         base, load_cyc, idle_cyc, load_at, starts, loads;
    bit         finished;
    exp_ef    = |err;
    exp_flags = {err, 1'b0};
    base      = exp_ef ? 1 : done_dly + 1;
`ifdef MTM_ALU_CTRL_TIMEOUT_EN
    if (!exp_ef && (done_dly == 0 || done_dly > TMO)) begin
      exp_ef = 1'b1; exp_flags = 4'b0001; base = TMO + 1;
    end
`endif
    load_cyc = base + hold;
    idle_cyc = load_cyc + ((tx_len > 1) ? tx_len : 1) + 2;
    load_at = -1; starts = 0; loads = 0; finished = 1'b0;

    checks++;
    if (des_ready !== 1'b1) begin
      $display("FAIL ready_before_frame got=%b exp=1", des_ready); failures++;
    end
    des_valid = 1'b1; des_err = err; core_done = 1'b0; ser_busy = 1'b0;
    next_cycle();
    des_valid = 1'b0; des_err = 3'b000;

    for (int c = 1; c < 200 && !finished; c++) begin
      core_done = (!(|err) && done_dly != 0 && c == done_dly) ||
                  (stray && load_at >= 0 && c == load_at + 1);
      if (load_at < 0) ser_busy = (c >= base && c < load_cyc);
      else             ser_busy = (c > load_at && c <= load_at + tx_len);
      des_valid = inject && c == 2;
      des_err   = (inject && c == 2) ? 3'b000 : 3'b000;
      #1;
      if (core_start) starts++;
      if (ser_load) begin
        loads++;
        if (load_at < 0) begin
          load_at = c;
          checks++;
          if (ser_err_frame !== exp_ef || ser_err_flags !== exp_flags) begin
            $display("FAIL load_flags got=%b/%b exp=%b/%b", ser_err_frame, ser_err_flags, exp_ef, exp_flags);
            failures++;
          end
        end
      end
      if (load_at >= 0 && c == load_at + 1) begin
        checks++;
        if (ser_err_frame !== exp_ef || ser_err_flags !== exp_flags || busy !== 1'b1) begin
          $display("FAIL tx_stable got=%b/%b/%b exp=%b/%b/1", ser_err_frame, ser_err_flags, busy, exp_ef, exp_flags);
          failures++;
        end
      end
      if (load_at >= 0 && des_ready) begin
        finished = 1'b1;
        checks++;
        if (c != idle_cyc) begin
          $display("FAIL idle_cycle got=%0d exp=%0d", c, idle_cyc); failures++;
        end
      end else begin
        @(posedge clk); #1;
      end
    end
    des_valid = 1'b0; core_done = 1'b0; ser_busy = 1'b0;

    checks++;
    if (!finished) begin
      $display("FAIL frame_timeout got=no_idle exp=idle_by_%0d", idle_cyc); failures++;
    end
    checks++;
    if (load_at != load_cyc) begin
      $display("FAIL load_cycle got=%0d exp=%0d", load_at, load_cyc); failures++;
    end
    checks++;
    if (starts != (|err ? 0 : 1) || loads != 1) begin
      $display("FAIL pulse_count got=start%0d/load%0d exp=start%0d/load1", starts, loads, |err ? 0 : 1);
      failures++;
    end

    n_frames++;
    if (exp_ef && n_errs < MAXC) n_errs++;
    if (inject) drop_exp = 1'b1;
    checks++;
    if (frame_cnt !== CNT_W'(n_frames % (MAXC + 1)) || err_cnt !== CNT_W'(n_errs) || drop !== drop_exp) begin
      $display("FAIL counters got=%0d/%0d/%b exp=%0d/%0d/%b", frame_cnt, err_cnt, drop,
               n_frames % (MAXC + 1), n_errs, drop_exp);
      failures++;
    end
    checks++;
    if (ser_err_frame !== 1'b0 || ser_err_flags !== 4'b0 || busy !== 1'b0) begin
      $display("FAIL idle_outputs got=%b/%b/%b exp=0/0000/0", ser_err_frame, ser_err_flags, busy);
      failures++;
    end
    $display("frame %0d err=%b done=%0d hold=%0d tx=%0d load@%0d fcnt=%0d ecnt=%0d drop=%b",
             n_frames, err, done_dly, hold, tx_len, load_at, frame_cnt, err_cnt, drop);
    next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; des_valid = 1'b0; des_err = 3'b000; core_done = 1'b0; ser_busy = 1'b0;
    next_cycle(); next_cycle();
    checks++;
    if (des_ready !== 1'b1 || core_start !== 1'b0 || ser_load !== 1'b0 || ser_err_frame !== 1'b0 ||
        ser_err_flags !== 4'b0 || busy !== 1'b0 || drop !== 1'b0 || frame_cnt !== '0 || err_cnt !== '0) begin
      $display("FAIL reset_state got=rdy%b st%b ld%b ef%b fl%b bz%b dr%b fc%0d ec%0d exp=rdy1_rest0",
               des_ready, core_start, ser_load, ser_err_frame, ser_err_flags, busy, drop, frame_cnt, err_cnt);
      failures++;
    end
    rst = 1'b0;
    next_cycle();
    $display("reset released des_ready=%b", des_ready);
  endtask

  task automatic test_good_frame();
    run_frame(3'b000, 5, 0, 4, 1'b0, 1'b0);
  endtask

  task automatic test_error_frame();
    run_frame(3'b010, 0, 0, 4, 1'b0, 1'b0);
    run_frame(3'b101, 0, 0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_frame(3'b000, 3, 4, 2, 1'b0, 1'b1);
    run_frame(3'b100, 0, 3, 0, 1'b0, 1'b0);
    run_frame(3'b000, 4, 0, 3, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [2:0] e;
      e = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      run_frame(e, $urandom_range(1, 12), $urandom_range(0, 3), $urandom_range(0, 5),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end
  endtask

`ifdef MTM_ALU_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    run_frame(3'b000, 0, 0, 2, 1'b0, 1'b0);
    run_frame(3'b000, TMO, 0, 2, 1'b0, 1'b0);
    run_frame(3'b000, TMO + 1, 1, 2, 1'b0, 1'b0);
  endtask
`endif

  task automatic test_reset_mid(input bit in_tx);
    int seen;
    des_valid = 1'b1; des_err = in_tx ? 3'b001 : 3'b000;
    next_cycle();
    des_valid = 1'b0; des_err = 3'b000;
    next_cycle();
    des_valid = 1'b1; ser_busy = in_tx;
    next_cycle();
    des_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (des_ready !== 1'b1 || busy !== 1'b0 || drop !== 1'b0 || frame_cnt !== '0 || err_cnt !== '0 ||
        core_start !== 1'b0 || ser_err_frame !== 1'b0 || ser_err_flags !== 4'b0) begin
      $display("FAIL reset_mid_%s got=rdy%b bz%b dr%b fc%0d ec%0d st%b ef%b exp=rdy1_rest0",
               in_tx ? "tx" : "calc", des_ready, busy, drop, frame_cnt, err_cnt, core_start, ser_err_frame);
      failures++;
    end
    next_cycle(); next_cycle();
    rst = 1'b0; ser_busy = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      core_done = c[0];
      #1;
      if (ser_load || core_start || !des_ready) seen++;
      next_cycle();
    end
    core_done = 1'b0;
    checks++;
    if (seen != 0) begin
      $display("FAIL reset_spurious_%s got=%0d exp=0", in_tx ? "tx" : "calc", seen); failures++;
    end
    n_frames = 0; n_errs = 0; drop_exp = 1'b0;
    $display("reset mid-%s done spurious=%0d", in_tx ? "tx" : "calc", seen);
  endtask

  task automatic test_counters();
    for (int i = 0; i < 17; i++)
      run_frame(3'($urandom_range(1, 7)), 0, 0, $urandom_range(1, 3), 1'b0, 1'b0);
    checks++;
    if (frame_cnt !== 4'd1 || err_cnt !== 4'd15) begin
      $display("FAIL counter_wrap_sat got=%0d/%0d exp=1/15", frame_cnt, err_cnt); failures++;
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_error_frame();
    test_backpressure();
    test_random();
`ifdef MTM_ALU_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    test_counters();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
